// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states, next-PC
// select codes and the default reset vector.
package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SEL_W   = 2;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_VALID = 2'd1,
    ST_HALT  = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_e;

  localparam logic [SEL_W-1:0] NPC_SEQ = 2'b00;
  localparam logic [SEL_W-1:0] NPC_BR  = 2'b01;
  localparam logic [SEL_W-1:0] NPC_J   = 2'b10;
  localparam logic [SEL_W-1:0] NPC_JR  = 2'b11;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC from the held instruction and its address, plus a
// flag for word-misaligned targets.
module npc_calc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0]  inst,
  input  logic [XLEN-1:0]  inst_pc,
  input  logic [SEL_W-1:0] npc_sel,
  input  logic [XLEN-1:0]  jr_target,
  output logic [XLEN-1:0]  npc_c,
  output logic             misaligned_c
);

  logic [XLEN-1:0] w_p4;
  logic [XLEN-1:0] w_br_off;
  logic            w_unused;

  assign w_p4     = inst_pc + XLEN'(4);
  assign w_br_off = {{14{inst[15]}}, inst[15:0], 2'b00};
  // opcode bits are decoded elsewhere
  assign w_unused = ^inst[31:26];

  always_comb begin
    npc_c = w_p4;
    case (npc_sel)
      NPC_SEQ: npc_c = w_p4;
      NPC_BR:  npc_c = w_p4 + w_br_off;
      NPC_J:   npc_c = {w_p4[31:28], inst[25:0], 2'b00};
      NPC_JR:  npc_c = jr_target;
      default: npc_c = w_p4;
    endcase
  end

  assign misaligned_c = (npc_c[1:0] != 2'b00);

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, runs the req/ack port into
// instruction memory and holds each word until decode consumes it.
module fetch_seq
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             im_req,
  output logic [XLEN-1:0]  im_addr,
  input  logic             im_ack,
  input  logic [XLEN-1:0]  im_rdata,
  output logic             inst_valid,
  output logic [XLEN-1:0]  inst,
  output logic [XLEN-1:0]  inst_pc,
  input  logic             inst_ready,
  input  logic [SEL_W-1:0] npc_sel,
  input  logic [XLEN-1:0]  jr_target,
  input  logic             halt_req,
  input  logic             resume,
  output logic             halted,
  output logic             fetch_err,
  output logic [XLEN-1:0]  err_pc,
  output logic [XLEN-1:0]  retired
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic [XLEN-1:0] r_err_pc;
  logic [XLEN-1:0] r_retired;
  logic            r_fetch_err;
  logic            r_im_req;
  logic            r_inst_valid;
  logic            r_halted;

  logic [XLEN-1:0] w_npc;
  logic            w_misaligned;
  logic            w_latch;
  logic            w_consume;
  logic            w_pc_ld;
  logic            w_err_set;
  logic [XLEN-1:0] w_err_val;

  npc_calc u_npc_calc (
    .inst         (r_inst),
    .inst_pc      (r_inst_pc),
    .npc_sel      (npc_sel),
    .jr_target    (jr_target),
    .npc_c        (w_npc),
    .misaligned_c (w_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Next state and datapath load enables; halt outranks a misaligned target.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_consume   = 1'b0;
    w_pc_ld     = 1'b0;
    w_err_set   = 1'b0;
    w_err_val   = r_err_pc;
    case (r_state)
      ST_FETCH: begin
        if (im_ack) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        if (inst_ready) begin
          w_consume = 1'b1;
          if (halt_req) begin
            w_pc_ld     = 1'b1;
            w_state_nxt = ST_HALT;
          end else if (w_misaligned) begin
            w_err_set   = 1'b1;
            w_err_val   = w_npc;
            w_state_nxt = ST_ERR;
          end else begin
            w_pc_ld     = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        if (resume) begin
          if (r_pc[1:0] != 2'b00) begin
            w_err_set   = 1'b1;
            w_err_val   = r_pc;
            w_state_nxt = ST_ERR;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_ERR:  w_state_nxt = ST_ERR;
      default: w_state_nxt = ST_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_err_pc     <= '0;
      r_retired    <= '0;
      r_fetch_err  <= 1'b0;
      r_im_req     <= 1'b1;
      r_inst_valid <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      if (w_latch) begin
        r_inst    <= im_rdata;
        r_inst_pc <= r_pc;
      end
      if (w_consume) r_retired <= r_retired + XLEN'(1);
      if (w_pc_ld)   r_pc      <= w_npc;
      if (w_err_set) begin
        r_err_pc    <= w_err_val;
        r_fetch_err <= 1'b1;
      end
      // Status flags track the state being entered so they stay registered.
      r_im_req     <= (w_state_nxt == ST_FETCH);
      r_inst_valid <= (w_state_nxt == ST_VALID);
      r_halted     <= (w_state_nxt == ST_HALT);
    end
  end

  assign im_req     = r_im_req;
  assign im_addr    = r_pc;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign halted     = r_halted;
  assign fetch_err  = r_fetch_err;
  assign err_pc     = r_err_pc;
  assign retired    = r_retired;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed scenarios plus randomized traffic, all
// checked against a transaction-level reference of the sequencer.
module tb_fetch_seq;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int M_FETCH = 0;
  localparam int M_VALID = 1;
  localparam int M_HALT  = 2;
  localparam int M_ERR   = 3;

  logic        clk;
  logic        rst_n;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [1:0]  npc_sel;
  logic [31:0] jr_target;
  logic        halt_req;
  logic        resume;
  logic        halted;
  logic        fetch_err;
  logic [31:0] err_pc;
  logic [31:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_mode;
  logic [31:0] m_pc, m_inst, m_ipc, m_errpc, m_ret;
  logic        m_err;

  fetch_seq #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_ack     (im_ack),
    .im_rdata   (im_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .npc_sel    (npc_sel),
    .jr_target  (jr_target),
    .halt_req   (halt_req),
    .resume     (resume),
    .halted     (halted),
    .fetch_err  (fetch_err),
    .err_pc     (err_pc),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_npc(input logic [31:0] ipc, input logic [31:0] ins,
                                          input logic [1:0] sel, input logic [31:0] jr);
    logic [31:0] p4;
    int          off;
    p4  = ipc + 32'd4;
    off = int'($signed(ins[15:0]));
    case (sel)
      2'd0:    return p4;
      2'd1:    return p4 + 32'(off * 4);
      2'd2:    return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      default: return jr;
    endcase
  endfunction

  task automatic model_reset();
    m_mode  = M_FETCH;
    m_pc    = RST_PC;
    m_inst  = '0;
    m_ipc   = '0;
    m_errpc = '0;
    m_ret   = '0;
    m_err   = 1'b0;
  endtask

  // One clock of the reference, using the inputs applied for that cycle.
  task automatic model_step();
    logic [31:0] npc;
    case (m_mode)
      M_FETCH: if (im_ack) begin
        m_inst = im_rdata;
        m_ipc  = m_pc;
        m_mode = M_VALID;
      end
      M_VALID: if (inst_ready) begin
        m_ret = m_ret + 32'd1;
        npc   = ref_npc(m_ipc, m_inst, npc_sel, jr_target);
        if (halt_req) begin
          m_pc = npc; m_mode = M_HALT;
        end else if (npc % 4 != 0) begin
          m_err = 1'b1; m_errpc = npc; m_mode = M_ERR;
        end else begin
          m_pc = npc; m_mode = M_FETCH;
        end
      end
      M_HALT: if (resume) begin
        if (m_pc % 4 != 0) begin
          m_err = 1'b1; m_errpc = m_pc; m_mode = M_ERR;
        end else begin
          m_mode = M_FETCH;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    check_eq("im_req", 32'(im_req), 32'(m_mode == M_FETCH));
    if (m_mode == M_FETCH) check_eq("im_addr", im_addr, m_pc);
    check_eq("inst_valid", 32'(inst_valid), 32'(m_mode == M_VALID));
    check_eq("halted", 32'(halted), 32'(m_mode == M_HALT));
    check_eq("inst", inst, m_inst);
    check_eq("inst_pc", inst_pc, m_ipc);
    check_eq("fetch_err", 32'(fetch_err), 32'(m_err));
    check_eq("err_pc", err_pc, m_errpc);
    check_eq("retired", retired, m_ret);
  endtask

  task automatic step(input logic ack, input logic [31:0] rd, input logic rdy,
                      input logic [1:0] sel, input logic [31:0] jr,
                      input logic hr, input logic res);
    im_ack = ack; im_rdata = rd; inst_ready = rdy;
    npc_sel = sel; jr_target = jr; halt_req = hr; resume = res;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, NPC_SEQ, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic fetch_ok(input logic [31:0] rd);
    step(1'b1, rd, 1'b0, NPC_SEQ, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic consume(input logic [1:0] sel, input logic [31:0] jr, input logic hr);
    step(1'b0, 32'h0, 1'b1, sel, jr, hr, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle, released on the following negedge.
  task automatic do_reset();
    #2;
    im_ack = 0; im_rdata = 0; inst_ready = 0; npc_sel = 0;
    jr_target = 0; halt_req = 0; resume = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    im_ack = 0; im_rdata = 0; inst_ready = 0; npc_sel = 0;
    jr_target = 0; halt_req = 0; resume = 0;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_all();
    check_eq("rst_im_req", 32'(im_req), 32'd1);
    check_eq("rst_im_addr", im_addr, 32'h0000_3000);
    rst_n = 1'b1;

    // Reset and first fetch with three wait states
    repeat (3) begin
      idle();
      check_eq("t1_addr_wait", im_addr, 32'h0000_3000);
    end
    fetch_ok(32'h2008_0005);
    check_eq("t1_valid", 32'(inst_valid), 32'd1);
    check_eq("t1_inst", inst, 32'h2008_0005);
    consume(NPC_SEQ, 32'h0, 1'b0);
    check_eq("t1_next_addr", im_addr, 32'h0000_3004);
    check_eq("t1_retired", retired, 32'd1);

    // Backward branch from 0x3010
    fetch_ok(32'h0);
    consume(NPC_JR, 32'h0000_3010, 1'b0);
    fetch_ok(32'h1000_FFFE);
    check_eq("t2_inst_pc", inst_pc, 32'h0000_3010);
    consume(NPC_BR, 32'h0, 1'b0);
    check_eq("t2_br_addr", im_addr, 32'h0000_300C);

    // Jump then register jump
    fetch_ok(32'h0);
    consume(NPC_JR, 32'h0000_3020, 1'b0);
    fetch_ok(32'h0800_0C10);
    consume(NPC_J, 32'h0, 1'b0);
    check_eq("t3_j_addr", im_addr, 32'h0000_3040);
    fetch_ok(32'h0);
    consume(NPC_JR, 32'h0000_3008, 1'b0);
    check_eq("t3_jr_addr", im_addr, 32'h0000_3008);

    // Halt and resume
    do_reset();
    fetch_ok(32'h0);
    consume(NPC_SEQ, 32'h0, 1'b1);
    repeat (5) begin
      idle();
      check_eq("t5_halted", 32'(halted), 32'd1);
      check_eq("t5_no_req", 32'(im_req), 32'd0);
    end
    step(1'b0, 32'h0, 1'b0, NPC_SEQ, 32'h0, 1'b0, 1'b1);
    check_eq("t5_resume_req", 32'(im_req), 32'd1);
    check_eq("t5_resume_addr", im_addr, 32'h0000_3004);

    // Reset mid-fetch, then back-pressure
    idle();
    idle();
    do_reset();
    check_eq("t6_rst_addr", im_addr, 32'h0000_3000);
    check_eq("t6_rst_retired", retired, 32'd0);
    fetch_ok(32'hDEAD_BEEF);
    repeat (10) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'b0, 2'($urandom_range(0, 3)),
           $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_eq("t6_inst_hold", inst, 32'hDEAD_BEEF);
      check_eq("t6_no_req", 32'(im_req), 32'd0);
    end
    consume(NPC_SEQ, 32'h0, 1'b0);

    // Misaligned register jump is terminal
    fetch_ok(32'h0);
    consume(NPC_JR, 32'h0000_3006, 1'b0);
    check_eq("t4_fetch_err", 32'(fetch_err), 32'd1);
    check_eq("t4_err_pc", err_pc, 32'h0000_3006);
    repeat (6) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_eq("t4_no_req", 32'(im_req), 32'd0);
    end

    // Randomized traffic with periodic resets
    for (int b = 0; b < 20; b++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        logic [31:0] jr;
        jr = ($urandom_range(0, 3) == 0) ? $urandom
                                         : RST_PC + 32'($urandom_range(0, 63) * 4);
        step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), jr,
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer for the MIPS core. It owns the PC and drives a request/acknowledge read port into the 4 KB instruction memory. It holds each fetched word for the decode stage until decode consumes it. On consumption it computes the next PC (sequential, branch, J/JAL, JR), and it supports halt/resume and misaligned-target trapping.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `im_req`  out  1  fetch request to instruction memory.
- `im_addr`  out  32  byte address of the requested word; equals current PC.
- `im_ack`  in  1  memory has returned `im_rdata` this cycle.
- `im_rdata`  in  32  instruction word.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a valid instruction.
- `inst`  out  32  held instruction.
- `inst_pc`  out  32  address of `inst`.
- `inst_ready`  in  1  decode consumes the held instruction this cycle.
- `npc_sel`  in  2  sampled on consume: 00 PC+4, 01 branch taken, 10 J/JAL, 11 JR.
- `jr_target`  in  32  register target for JR.
- `halt_req`  in  1  on consume, stop after this instruction.
- `resume`  in  1  leave HALT.
- `halted`  out  1  in HALT.
- `fetch_err`  out  1  sticky; misaligned target detected.
- `err_pc`  out  32  offending target address.
- `retired`  out  32  count of consumed instructions.

## Operation
- FSM states: FETCH, VALID, HALT, ERR. Reset state is FETCH.
- **FETCH**
  - `im_req`=1 and `im_addr`=pc.
  - On `im_ack`: latch `inst`<=`im_rdata` and `inst_pc`<=pc, then go to VALID.
- **VALID**
  - `inst_valid`=1 and `im_req`=0.
  - When `inst_ready`=1 (consume):
    - Increment `retired`.
    - Compute npc.
    - If `halt_req`, go to HALT with pc<=npc.
    - Otherwise, if npc[1:0]≠0, go to ERR with `err_pc`<=npc and `fetch_err`<=1.
    - Otherwise pc<=npc and go to FETCH.
- **HALT**
  - `halted`=1.
  - `resume` returns to FETCH with the stored pc, so the misalignment check still applies before the fetch.
  - A misaligned stored pc goes to ERR instead.
- **ERR**: terminal until reset. No requests are issued and `inst_valid`=0.
- npc arithmetic, all with wrap modulo 2^32:
  - p4 = `inst_pc`+4.
  - Branch: p4 + (sign-extend `inst`[15:0] << 2).
  - J/JAL: {p4[31:28], `inst`[25:0], 2'b00}.
  - JR: `jr_target`.
- Immediates are taken from the held `inst`, not from decode, so decode supplies only `npc_sel`.
- `retired` wraps from 32'hFFFF_FFFF to 0.
- `npc_sel`, `halt_req` and `jr_target` are ignored when no consume occurs.
- `resume` is ignored outside HALT.

## Timing
- Reset values:
  - pc=`RESET_PC`, `inst`=0, `inst_pc`=0, `err_pc`=0, `retired`=0.
  - `inst_valid`=0, `halted`=0, `fetch_err`=0.
  - `im_req`=1, because the state is FETCH.
- Handshake:
  - Once `im_req` is raised, it and `im_addr` stay stable until the cycle `im_ack` is seen.
  - `im_ack` is allowed in the same cycle `im_req` rises, which gives zero wait states.
  - `im_ack` while `im_req`=0 is ignored.
- Latency with zero wait states: a new instruction is presented every 2 cycles at best (FETCH 1 cycle, VALID ≥1 cycle).
- `inst_valid` rises the cycle after the ack edge. `inst` is registered, not combinational from `im_rdata`.
- Asynchronous reset mid-fetch abandons the outstanding request. Memory must tolerate request withdrawal.
- `halt_req` and a misaligned npc in the same consume: HALT takes priority. The fault is reported on resume.
- `resume` and reset together: reset wins.

## Structure
- Shared `mips_pkg` holds:
  - state encoding constants;
  - `npc_sel` codes `NPC_SEQ`, `NPC_BR`, `NPC_J`, `NPC_JR`;
  - the default reset vector.
- One sub-module, `npc_calc`: combinational npc from `inst`, `inst_pc`, `npc_sel`, `jr_target`. It also produces the misaligned flag.

## Test plan
1. **Reset and first fetch.**
   - Stimulus: release reset; ack with 32'h2008_0005 after 3 wait cycles; assert `inst_ready`.
   - Required response:
     - `im_addr`=32'h0000_3000 stable throughout the wait;
     - `inst_valid`=1 one cycle after the ack;
     - next `im_addr`=32'h0000_3004;
     - `retired`=1.
2. **Branch.**
   - Stimulus: `inst_pc`=32'h0000_3010, `inst`[15:0]=16'hFFFE, `npc_sel`=01.
   - Required response: next `im_addr`=32'h0000_300C.
3. **Jump, then JR.**
   - J with `inst_pc`=32'h0000_3020, `inst`[25:0]=26'h0000C10 -> next `im_addr`=32'h0000_3040.
   - JR with `jr_target`=32'h0000_3008 -> next `im_addr`=32'h0000_3008.
4. **Misaligned JR.**
   - Stimulus: `jr_target`=32'h0000_3006.
   - Required response: `fetch_err`=1 and `err_pc`=32'h0000_3006; `im_req` stays 0 until reset.
5. **Halt and resume.**
   - Stimulus: `halt_req` on consume at `inst_pc`=32'h0000_3000; hold 5 cycles; pulse `resume`.
   - Required response: `halted`=1 and no requests during the hold; then fetch of 32'h0000_3004.
6. **Reset mid-fetch and back-pressure.**
   - Reset during FETCH with no ack -> `im_addr` returns to `RESET_PC` and `retired`=0.
   - `inst_ready`=0 for 10 cycles -> `inst` stable and no new `im_req`.
